// File: rtl/prbs_stream_gen.sv
// rtl/prbs_stream_gen.sv - PRBS beat source from a Fibonacci LFSR, counted or continuous bursts on a valid/ready stream.
// Optional build macro PRBS_STREAM_ERR_INJECT_EN adds err_inject, which flips bit 0 of the next loaded beat.
module prbs_stream_gen #(
    parameter int DataBits = 32,
    parameter int LfsrBits = 17,
    parameter logic [LfsrBits-1:0] TapMask = 17'h00009,
    parameter logic [LfsrBits-1:0] LfsrSeed = 17'h15555,
    parameter int LenBits = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LfsrBits-1:0] seed,
    input  logic                init,
    input  logic                start,
    input  logic [LenBits-1:0]  burst_len,
    input  logic                stop,
`ifdef PRBS_STREAM_ERR_INJECT_EN
    input  logic                err_inject,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DataBits-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [LenBits-1:0]  beat_count
);

    localparam int StreamBits = DataBits + LfsrBits;

    typedef enum logic {IDLE, RUN} state_t;

    // Unrolls the sequence far enough to yield one beat plus the following LFSR window.
    function automatic logic [StreamBits-1:0] gen_stream(input logic [LfsrBits-1:0] r);
        logic [StreamBits-1:0] s;
        logic b;
        s = '0;
        s[LfsrBits-1:0] = r;
        for (int i = LfsrBits; i < StreamBits; i++) begin
            b = 1'b0;
            for (int k = 0; k < LfsrBits; k++) begin
                if (TapMask[k]) b = b ^ s[i-LfsrBits+k];
            end
            s[i] = b;
        end
        return s;
    endfunction

    state_t                state, state_n;
    logic [LfsrBits-1:0]   lfsr_reg, lfsr_n;
    logic [LenBits-1:0]    len_reg, len_n;
    logic [LenBits-1:0]    count_n;
    logic [DataBits-1:0]   data_n;
    logic                  valid_n, last_n, busy_n, done_n;
    logic                  stop_pend, stop_n;
    logic                  load;
    logic [StreamBits-1:0] stream;
    logic [DataBits-1:0]   beat;

    assign stream = gen_stream(lfsr_reg);

`ifdef PRBS_STREAM_ERR_INJECT_EN
    logic armed, armed_n;
    always_comb begin
        armed_n = armed;
        if (load) armed_n = 1'b0;
        if (err_inject) armed_n = 1'b1;
        beat = stream[DataBits-1:0] ^ DataBits'(armed);
    end
`else
    assign beat = stream[DataBits-1:0];
`endif

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr_reg;
        len_n   = len_reg;
        count_n = beat_count;
        data_n  = out_data;
        valid_n = out_valid;
        last_n  = out_last;
        busy_n  = busy;
        done_n  = 1'b0;
        stop_n  = stop_pend;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    lfsr_n = (seed == '0) ? LfsrSeed : seed;
                end else if (start) begin
                    len_n   = burst_len;
                    count_n = '0;
                    load    = 1'b1;
                    last_n  = (burst_len == LenBits'(1));
                    stop_n  = 1'b0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop) stop_n = 1'b1;
                if (out_valid && out_ready) begin
                    count_n = beat_count + 1'b1;
                    // A stop seen on the accepting cycle ends the run on that same accept.
                    if (out_last || stop_pend || stop) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        stop_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        load   = 1'b1;
                        last_n = (len_reg != '0) && (count_n == len_reg - 1'b1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            data_n = beat;
            lfsr_n = stream[StreamBits-1:DataBits];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr_reg   <= LfsrSeed;
            len_reg    <= '0;
            beat_count <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stop_pend  <= 1'b0;
`ifdef PRBS_STREAM_ERR_INJECT_EN
            armed      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            lfsr_reg   <= lfsr_n;
            len_reg    <= len_n;
            beat_count <= count_n;
            out_data   <= data_n;
            out_valid  <= valid_n;
            out_last   <= last_n;
            busy       <= busy_n;
            done       <= done_n;
            stop_pend  <= stop_n;
`ifdef PRBS_STREAM_ERR_INJECT_EN
            armed      <= armed_n;
`endif
        end
    end

endmodule

// File: tb/tb_prbs_stream_gen.sv
// tb/tb_prbs_stream_gen.sv - self-checking bench for prbs_stream_gen against a bit-serial sequence model.
module tb_prbs_stream_gen;

    localparam int DW = 32;
    localparam int LW = 17;
    localparam int CW = 16;
    localparam logic [LW-1:0] TAP  = 17'h00009;
    localparam logic [LW-1:0] SEED = 17'h15555;

    logic          clk, rst;
    logic [LW-1:0] seed;
    logic          init, start, stop, out_ready;
    logic [CW-1:0] burst_len;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] out_data;
    logic [CW-1:0] beat_count;
`ifdef PRBS_STREAM_ERR_INJECT_EN
    logic          err_inject;
    int            inj_diffs;
`endif

    prbs_stream_gen dut (
        .clk(clk), .rst(rst), .seed(seed), .init(init), .start(start),
        .burst_len(burst_len), .stop(stop),
`ifdef PRBS_STREAM_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the whole PRBS stream as a growing bit list; beats are consecutive 32-bit slices.
    bit            seq[$];
    int            ptr;
    bit            m_run, m_valid, m_done, m_stop;
    logic [DW-1:0] m_data;
    int            m_idx;
    logic [CW-1:0] m_len, m_count;
    logic [DW-1:0] cap[$];

    task automatic reseed(input logic [LW-1:0] sd);
        seq.delete();
        for (int k = 0; k < LW; k++) seq.push_back(sd[k]);
        ptr = 0;
    endtask

    task automatic take_beat(output logic [DW-1:0] d);
        bit b;
        while (seq.size() < ptr + DW) begin
            b = 1'b0;
            for (int k = 0; k < LW; k++)
                if (TAP[k]) b = b ^ seq[seq.size() - LW + k];
            seq.push_back(b);
        end
        for (int j = 0; j < DW; j++) d[j] = seq[ptr + j];
        ptr = ptr + DW;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            reseed(SEED);
            m_run = 0; m_valid = 0; m_done = 0; m_stop = 0;
            m_count = '0; m_idx = 0; m_len = '0; m_data = '0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (init) reseed((seed == '0) ? SEED : seed);
                else if (start) begin
                    m_len = burst_len; m_count = '0; m_idx = 1; m_stop = 0;
                    take_beat(m_data);
                    m_valid = 1; m_run = 1;
                end
            end else begin
                if (stop) m_stop = 1;
                if (out_ready) begin
                    m_count = m_count + 16'd1;
                    if ((m_len != 0 && m_idx == int'(m_len)) || m_stop) begin
                        m_run = 0; m_valid = 0; m_done = 1;
                    end else begin
                        m_idx++;
                        take_beat(m_data);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("valid", 64'(out_valid), 64'(m_valid));
            check("busy", 64'(busy), 64'(m_run));
            check("done", 64'(done), 64'(m_done));
            check("count", 64'(beat_count), 64'(m_count));
            if (m_valid && out_valid) begin
`ifdef PRBS_STREAM_ERR_INJECT_EN
                if (out_data != m_data) begin
                    inj_diffs++;
                    check("inj_bit0_only", 64'(out_data ^ m_data), 64'd1);
                end
`else
                check("data", 64'(out_data), 64'(m_data));
`endif
                check("last", 64'(out_last), 64'(m_len != 0 && m_idx == int'(m_len)));
                if (out_ready) cap.push_back(out_data);
            end
        end
    end

    task automatic do_start(input logic [CW-1:0] len);
        start = 1'b1;
        burst_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (done) begin found = 1; break; end
        end
        check("done_seen", 64'(found), 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #4;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_count"}, 64'(beat_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; init = 0; start = 0; stop = 0; seed = '0; burst_len = '0; out_ready = 0;
`ifdef PRBS_STREAM_ERR_INJECT_EN
        err_inject = 0; inj_diffs = 0;
`endif
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Counted burst of 3, always ready.
        cap.delete();
        out_ready = 1'b1;
        do_start(16'd3);
        check("t1_valid_rise", 64'(out_valid), 64'd1);
        check("t1_first_beat", 64'(out_data), 64'h7FFF5555);
        check("t1_model_pin", 64'(m_data), 64'h7FFF5555);
        wait_done(0);
        check("t1_count", 64'(beat_count), 64'd3);
        check("t1_beats", 64'(cap.size()), 64'd3);

        // Same burst with random stalls.
        pulse_reset();
        cap.delete();
        do_start(16'd3);
        check("t2_first_beat", 64'(out_data), 64'h7FFF5555);
        wait_done(1);
        check("t2_beats", 64'(cap.size()), 64'd3);
        check("t2_count_hold", 64'(beat_count), 64'd3);

        // init beats a same-cycle start; a zero seed falls back to the default seed.
        init = 1'b1; seed = '0; start = 1'b1; burst_len = 16'd1;
        @(posedge clk); #1;
        init = 1'b0; start = 1'b0;
        check("t3_start_ignored", 64'(out_valid), 64'd0);
        do_start(16'd1);
        check("t3_first_beat", 64'(out_data), 64'h7FFF5555);
        check("t3_last", 64'(out_last), 64'd1);
        wait_done(0);
        check("t3_count", 64'(beat_count), 64'd1);

        // Nonzero seed: s0=1, s17=1, s31=1.
        init = 1'b1; seed = 17'h00001;
        @(posedge clk); #1;
        init = 1'b0;
        do_start(16'd2);
        check("t3b_seed1_beat", 64'(out_data), 64'h80020001);
        wait_done(0);

        // Continuous mode stopped while a beat is stalled.
        out_ready = 1'b1;
        do_start(16'd0);
        for (int i = 0; i < 50; i++) begin
            if (beat_count == 16'd5) break;
            @(posedge clk); #1;
        end
        check("t4_five_accepts", 64'(beat_count), 64'd5);
        out_ready = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("t4_sixth_held", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        wait_done(0);
        check("t4_count", 64'(beat_count), 64'd6);
        check("t4_valid_low", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-burst.
        out_ready = 1'b1;
        do_start(16'd10);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(16'd5);
        check("t5_first_beat", 64'(out_data), 64'h7FFF5555);
        wait_done(0);
        check("t5_count", 64'(beat_count), 64'd5);

        // Back-to-back bursts continue the sequence.
        do_start(16'd2);
        wait_done(1);
        do_start(16'd2);
        wait_done(0);
        check("t6_count", 64'(beat_count), 64'd2);

`ifdef PRBS_STREAM_ERR_INJECT_EN
        inj_diffs = 0;
        do_start(16'd4);
        err_inject = 1'b1;
        @(posedge clk); #1;
        err_inject = 1'b0;
        wait_done(0);
        check("inj_one_beat", 64'(inj_diffs), 64'd1);
`endif

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
